// File: rtl/vga_sync_if.sv
// vga_sync_if: raster bus from vga_sync_gen to the downstream pixel/object logic.
//   HCount, VCount  10-bit raster coordinates (column, line)
//   hsync, vsync    sync levels for the VGA connector
//   video_on        high while the coordinates are in the visible area
//   pixel_tick      one-clk strobe; the coordinates advance at the end of it
//   frame_tick      one-clk strobe in the clk where the raster has wrapped to (0,0)
// master: the timing generator drives everything; slave: consumers observe it.
interface vga_sync_if;
  logic [9:0] HCount;
  logic [9:0] VCount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       pixel_tick;
  logic       frame_tick;

  modport master (
    output HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_tick
  );

  modport slave (
    input HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
// A clk divider produces the pixel enable; a column/line counter pair walks the
// raster, and sync/visible flags are decoded from the same next-state values
// the counters load, so all outputs stay aligned to HCount/VCount.
// Ports:
//   clk      system clock
//   reset_n  synchronous reset, active-low
//   vga      vga_sync_if.master: HCount, VCount, hsync, vsync, video_on,
//            pixel_tick, frame_tick
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter bit SYNC_POL  = 1'b0
) (
  input logic        clk,
  input logic        reset_n,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             frame_wrap;
  logic             pixel_tick_q;
  logic             frame_tick_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             video_on_q;

  // Next-state of divider and raster. The counters move only in the clk where
  // pixel_tick is high, so the strobe seen downstream marks the last clk of a pixel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    div_next   = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
    h_next     = h_cnt;
    v_next     = v_cnt;
    frame_wrap = 1'b0;
    if (pixel_tick_q) begin
      if (h_cnt == H_LAST) begin
        h_next = '0;
        if (v_cnt == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = v_cnt + 10'd1;
        end
      end else begin
        h_next = h_cnt + 10'd1;
      end
    end
  end

  // NOTE: reset is sampled only on the clock edge, so it sits inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt      <= '0;
      pixel_tick_q <= 1'b0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      frame_tick_q <= 1'b0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      video_on_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      div_cnt      <= div_next;
      // High for the clk in which the divider sits at its last count; with
      // CLK_DIV=1 this is permanently high once out of reset.
      pixel_tick_q <= (div_next == DIV_LAST);
      h_cnt        <= h_next;
      v_cnt        <= v_next;
      frame_tick_q <= frame_wrap;
      // Decoded from the next counter values so the flags land in the same
      // clk as the coordinates they describe.
      hsync_q      <= ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vsync_q      <= ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      video_on_q   <= (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

  assign vga.HCount     = h_cnt;
  assign vga.VCount     = v_cnt;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = video_on_q;
  assign vga.pixel_tick = pixel_tick_q;
  assign vga.frame_tick = frame_tick_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing source for the display pipeline. Produces the HCount/VCount raster coordinates that object_square and the other object blocks decode into *_on flags.
- Also produces hsync/vsync for the VGA connector, plus video_on and pixel_tick/frame_tick strobes for downstream pixel logic.
- Default timing is 640x480 @ 60 Hz from a 50 MHz board clock with a divide-by-2 pixel enable.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  synchronous reset, active-low
- HCount  out  10  current pixel column, 0..H_TOTAL-1
- VCount  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync to connector
- vsync  out  1  vertical sync to connector
- video_on  out  1  high while (HCount,VCount) is in the visible area
- pixel_tick  out  1  one-clk pulse; counters advance on it
- frame_tick  out  1  one-clk pulse when the raster wraps to (0,0)

Behaviour:
- Interface: one clock, clk. reset_n is synchronous, active-low: sampled only on the rising edge of clk.
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = 525.
- Reset (reset_n=0 at an edge):
  - div counter = 0; HCount = 0; VCount = 0.
  - pixel_tick = 0; frame_tick = 0; video_on = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
- Reset mid-frame: same values at the next edge; no partial-line completion.
- Pixel divider:
  - The counter counts 0..CLK_DIV-1 and wraps.
  - pixel_tick = 1 for exactly one clk, when the divider is at CLK_DIV-1.
  - CLK_DIV=1: pixel_tick is constantly 1 after reset.
- Raster counters update only in the clk where pixel_tick=1:
  - HCount = H_TOTAL-1 -> HCount = 0 and VCount increments.
  - VCount = V_TOTAL-1 at the same time -> VCount = 0.
  - Otherwise HCount increments.
  - Counters hold between ticks.
- frame_tick = 1 in the single clk where HCount and VCount wrap together to (0,0) on a pixel_tick; 0 otherwise.
- Sync, video_on: registered. Computed from the next counter values, so they are aligned with HCount/VCount in the same cycle (zero relative latency).
  - hsync active iff H_DISPLAY+H_FRONT <= HCount <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync active iff V_DISPLAY+V_FRONT <= VCount <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
  - video_on iff HCount < H_DISPLAY and VCount < V_DISPLAY.
- First clk after reset release: counters are (0,0), so video_on becomes 1 at that edge; syncs stay inactive.
- Width rules:
  - Counters are 10 bits. Parameters must give H_TOTAL, V_TOTAL <= 1024.
  - Comparisons are unsigned.
  - No overflow path exists because the wrap precedes 1023.
- No states beyond divider and counters. hsync/vsync never glitch, since they change only on clk edges.

Test Plan:
- Reset: hold reset_n=0 for 5 clks with counters mid-frame (e.g. 300,200) -> next edge HCount=0, VCount=0, hsync=vsync=1, video_on=0, ticks=0. Release -> video_on=1 at first edge, HCount=0 until the first pixel_tick.
- Divider: CLK_DIV=2 -> pixel_tick alternates 0/1. HCount goes 0->1 after 2 clks and reaches 799 after 1600 clks from reset release, minus the first tick offset. Check pixel_tick period = 2 clks exactly.
- Line wrap/hsync:
  - HCount 655->656: hsync falls.
  - 751->752: hsync rises (96 pixels = 192 clks low).
  - 639->640: video_on falls.
  - 799->0: VCount increments and video_on rises (VCount<480).
- Frame wrap/vsync:
  - VCount 490: vsync low for exactly 2 lines (3200 clks).
  - At (799,524) + tick -> (0,0) with frame_tick=1 for one clk.
  - frame_tick period = 840000 clks.
- Visible-area edges against object_square: at (280,60) and (639,479) video_on=1; at (640,479) and (0,480) video_on=0.
- Reset asserted on the same edge as a frame wrap (HCount=799, VCount=524, pixel_tick=1) -> reset wins: counters 0, frame_tick=0.
